aes_inv_round_ctrl: RTL and testbench
=====================================

// Module: aes_inv_round_ctrl
// PURPOSE
//  Iterative AES decryption sequencer. Owns the 128-bit cipher-state register,
//  a round counter and in/out valid/ready handshakes. Drives one external
//  combinational inverse round datapath per cycle: InvShiftRows (shift128_inv),
//  InvSubBytes, AddRoundKey, then InvMixColumns unless rnd_last. Round keys come
//  from an external key store with a combinational read.
// PARAMETERS
//  NR         10  number of AES rounds (10/12/14 for AES-128/192/256)
//  KIDX_W      4  width of key_idx; must satisfy 2**KIDX_W > NR
// PORTS
//  clk        in    1    clock, rising edge
//  rst        in    1    asynchronous reset, active-high
//  clr        in    1    synchronous abort; returns the block to IDLE
//  in_valid   in    1    din is valid
//  in_ready   out   1    block can accept din
//  din        in    128  ciphertext block
//  out_valid  out   1    dout holds a finished plaintext block
//  out_ready  in    1    consumer accepts dout
//  dout       out   128  plaintext; equals the state register
//  key_idx    out   KIDX_W  round-key index requested this cycle
//  key_in     in    128  round key for key_idx, valid in the same cycle
//  rnd_in     out   128  state fed to the round datapath; equals the state register
//  rnd_last   out   1    final round; datapath bypasses InvMixColumns
//  rnd_out    in    128  datapath result, combinational from rnd_in/key_in/rnd_last
//  busy       out   1    high in RUN or DONE
// BEHAVIOUR
//  Reset is asynchronous and active-high. On rst: state=0, rnd=0, fsm=IDLE,
//   out_valid=0, in_ready=1, busy=0, rnd_last=0, key_idx=NR.
//  States:
//   IDLE: in_ready=1, key_idx=NR. On in_valid: state<=din^key_in (whitening
//    with rk[NR]), rnd<=NR-1, go to RUN.
//   RUN: in_ready=0, key_idx=rnd, rnd_last=(rnd==0). Each cycle:
//    state<=rnd_out. If rnd!=0, rnd<=rnd-1. If rnd==0, go to DONE.
//   DONE: out_valid=1, key_idx=NR. dout stays stable until out_ready.
//    On out_ready, go to IDLE. IDLE accepts no input in the same cycle,
//    so back-to-back blocks have a 1-cycle bubble.
//  Latency: accept edge E0, NR round edges E1..ENR. out_valid is high after
//   ENR, i.e. NR+1 edges from acceptance. Throughput is 1 block per NR+2 cycles
//   with out_ready held high.
//  key_idx counts NR (whitening), then NR-1 down to 0. It never wraps.
//   rnd saturates at 0.
//  Outside RUN, rnd_last=0.
//  clr has priority over every transition. Next edge: fsm=IDLE, out_valid=0,
//   rnd=0. The state register is left unchanged. A clr in IDLE that coincides
//   with in_valid drops the input and no handshake occurs.
//  in_valid while not in IDLE is ignored; in_ready=0 there.
//  An asynchronous rst mid-RUN or in DONE aborts immediately. Any pending
//   output is discarded.
//  All XOR work is 128-bit and bitwise. There is no other arithmetic on state.
// TESTING
//  T1 FIPS-197 C.1: key 000102..0f, din 69c4e0d86a7b0430d8cdb78070b4c55a,
//   out_ready=1 -> out_valid after 11 edges, dout 00112233445566778899aabbccddeeff.
//  T2 key_idx trace for T1 -> sequence 10,9,8,..,1,0 on accept..final edges;
//   rnd_last high only in the cycle with key_idx=0.
//  T3 backpressure: out_ready=0 for 5 cycles after out_valid -> dout/out_valid
//   stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
//  T4 abort: clr pulsed at RUN rnd=5 -> IDLE next edge, out_valid never rises;
//   a following T1 block still decrypts correctly.
//  T5 reset: rst asserted asynchronously mid-RUN -> out_valid=0, busy=0
//   immediately; clean decrypt after release.
//  T6 NR=14 with the AES-256 C.3 vector (key 00..1f, din 8ea2b7ca516745bfeafc49904b496089)
//   -> dout 00112233..eeff after 15 edges.

Source files
------------

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES decryption sequencer.
// Owns the cipher state and round count; the inverse round logic is external.
module aes_inv_round_ctrl #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      dout,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      key_in,
    output logic [127:0]      rnd_in,
    output logic              rnd_last,
    input  logic [127:0]      rnd_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [KIDX_W-1:0] KIDX_NR    = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_FIRST = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] KIDX_ONE   = KIDX_W'(1);

    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [127:0]      state_q;
    logic [KIDX_W-1:0] rnd_q;
    logic              rnd_zero;
    logic              accept;

    assign rnd_zero = (rnd_q == '0);
    assign accept   = (fsm_q == IDLE) && in_valid && !clr;
    assign dout     = state_q;
    assign rnd_in   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Whitening with rk[NR] happens on the accept edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            rnd_q   <= '0;
        end else if (clr) begin
            rnd_q <= '0;
        end else if (accept) begin
            state_q <= din ^ key_in;
            rnd_q   <= KIDX_FIRST;
        end else if (fsm_q == RUN) begin
            state_q <= rnd_out;
            if (!rnd_zero) begin
                rnd_q <= rnd_q - KIDX_ONE;
            end
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE: if (in_valid) fsm_d = RUN;
            RUN: if (rnd_zero) fsm_d = DONE;
            DONE: if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        if (clr) begin
            fsm_d = IDLE;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rnd_last  = 1'b0;
        key_idx   = KIDX_NR;
        unique case (fsm_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy     = 1'b1;
                key_idx  = rnd_q;
                rnd_last = rnd_zero;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: bench with an AES inverse round datapath, key store
// and a forward-cipher reference for random blocks.
module tb_aes_inv_round_ctrl;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;

    logic         a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [127:0] a_din = '0;
    logic         a_in_ready, a_out_valid, a_rnd_last, a_busy;
    logic [127:0] a_dout, a_rnd_in, a_rnd_out, a_key;
    logic [3:0]   a_key_idx;

    logic         b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [127:0] b_din = '0;
    logic         b_in_ready, b_out_valid, b_rnd_last, b_busy;
    logic [127:0] b_dout, b_rnd_in, b_rnd_out, b_key;
    logic [3:0]   b_key_idx;

    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [127:0] rk_a [16];
    logic [127:0] rk_b [16];

    always #5 clk = ~clk;

    aes_inv_round_ctrl #(.NR(10), .KIDX_W(4)) dut_a (
        .clk(clk), .rst(rst), .clr(a_clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout),
        .key_idx(a_key_idx), .key_in(a_key), .rnd_in(a_rnd_in),
        .rnd_last(a_rnd_last), .rnd_out(a_rnd_out), .busy(a_busy)
    );

    aes_inv_round_ctrl #(.NR(14), .KIDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
        .key_idx(b_key_idx), .key_in(b_key), .rnd_in(b_rnd_in),
        .rnd_last(b_rnd_last), .rnd_out(b_rnd_out), .busy(b_busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Column mix: forward uses row 02 03 01 01, inverse 0e 0b 0d 09.
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   v;
        logic [127:0] o;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(j+4*c) -: 8];
            for (int r = 0; r < 4; r++) begin
                v = '0;
                for (int j = 0; j < 4; j++) v = v ^ gmul(m[(j-r+4)%4], a[j]);
                o[127-8*(r+4*c) -: 8] = v;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[127-8*(r+4*c) -: 8] = isb[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
        t = t ^ k;
        if (!last) t = mix(t, 1'b1);
        return t;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s;
        logic [127:0] t;
        s = p ^ rk_a[0];
        for (int n = 1; n <= 10; n++) begin
            t = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[127-8*(r+4*c) -: 8] = sb[s[127-8*(r+4*((c+r)%4)) -: 8]];
            if (n != 10) t = mix(t, 1'b0);
            s = t ^ rk_a[n];
        end
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    always_comb a_key = rk_a[a_key_idx];
    always_comb b_key = rk_b[b_key_idx];
    always_comb a_rnd_out = inv_round(a_rnd_in, a_key, a_rnd_last);
    always_comb b_rnd_out = inv_round(b_rnd_in, b_key, b_rnd_last);

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ rl1(b) ^ rl1(rl1(b)) ^ rl1(rl1(rl1(b)))
                  ^ rl1(rl1(rl1(rl1(b)))) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk,
                              input int nr, input bit to_b);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] k;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            k = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            if (to_b) rk_b[r] = k;
            else rk_a[r] = k;
        end
    endtask

    task automatic drive_a(input logic [127:0] ct, output int cyc);
        int n;
        n = 0;
        while (!a_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        a_din = ct;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        cyc = 1;
        while (!a_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (n == 20) cyc = -1;
    endtask

    task automatic test_reset();
        a_in_valid = 1'b1;
        a_din = '1;
        repeat (2) @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", a_busy); end
        checks++; if (a_rnd_last !== 1'b0) begin fails++; $display("FAIL reset_rnd_last got %b want 0", a_rnd_last); end
        checks++; if (a_key_idx !== 4'd10) begin fails++; $display("FAIL reset_key_idx got %0d want 10", a_key_idx); end
        checks++; if (a_dout !== 128'h0) begin fails++; $display("FAIL reset_dout got %h want 0", a_dout); end
        checks++; if (b_key_idx !== 4'd14) begin fails++; $display("FAIL reset_key_idx_nr14 got %0d want 14", b_key_idx); end
        a_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_idle busy %b in_ready %b want 0 1", a_busy, a_in_ready); end
    endtask

    task automatic test_fips128();
        int  kq[$];
        bit  lq[$];
        int  cyc;
        int  ek;
        expand_key({K128, 128'h0}, 4, 10, 1'b0);
        a_out_ready = 1'b1;
        kq.push_back(int'(a_key_idx));
        lq.push_back(a_rnd_last);
        a_din = CT128;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        cyc = 1;
        while (!a_out_valid && cyc < 40) begin
            kq.push_back(int'(a_key_idx));
            lq.push_back(a_rnd_last);
            checks++; if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin fails++; $display("FAIL run_flags in_ready %b busy %b want 0 1", a_in_ready, a_busy); end
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 11) begin fails++; $display("FAIL fips128_latency got %0d want 11", cyc); end
        checks++; if (a_dout !== PT) begin fails++; $display("FAIL fips128_dout got %h want %h", a_dout, PT); end
        checks++; if (kq.size() != 11) begin fails++; $display("FAIL key_trace_len got %0d want 11", kq.size()); end
        else begin
            for (int i = 0; i <= 10; i++) begin
                ek = (i == 0) ? 10 : 10 - i;
                checks++; if (kq[i] != ek || lq[i] != (i == 10)) begin fails++; $display("FAIL key_trace[%0d] got %0d/%0b want %0d/%0b", i, kq[i], lq[i], ek, i == 10); end
            end
        end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL fips128_release out_valid %b in_ready %b want 0 1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_backpressure();
        int cyc;
        a_out_ready = 1'b0;
        drive_a(CT128, cyc);
        checks++; if (cyc != 11) begin fails++; $display("FAIL bp_latency got %0d want 11", cyc); end
        for (int h = 0; h < 5; h++) begin
            checks++; if (a_out_valid !== 1'b1 || a_dout !== PT || a_in_ready !== 1'b0 || a_busy !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] ov %b ir %b busy %b dout %h want 1 0 1 %h", h, a_out_valid, a_in_ready, a_busy, a_dout, PT); end
            a_in_valid = 1'b1;
            a_din = rnd128();
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_dout !== PT) begin fails++; $display("FAIL bp_release ov %b ir %b dout %h want 0 1 %h", a_out_valid, a_in_ready, a_dout, PT); end
    endtask

    task automatic test_abort();
        logic [127:0] saved;
        int n;
        int cyc;
        bit seen;
        a_out_ready = 1'b1;
        a_din = CT128;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        n = 0;
        while (!(a_busy && a_key_idx == 4'd5) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 20) begin fails++; $display("FAIL abort_reach_rnd5 got timeout want rnd 5"); end
        saved = a_dout;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_key_idx !== 4'd10) begin fails++; $display("FAIL abort_idle ir %b busy %b ov %b kidx %0d want 1 0 0 10", a_in_ready, a_busy, a_out_valid, a_key_idx); end
        checks++; if (a_dout !== saved) begin fails++; $display("FAIL abort_state_kept got %h want %h", a_dout, saved); end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin fails++; $display("FAIL abort_no_output got out_valid 1 want 0"); end
        a_clr = 1'b1;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        a_in_valid = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_dout !== saved) begin fails++; $display("FAIL clr_drops_input busy %b ir %b dout %h want 0 1 %h", a_busy, a_in_ready, a_dout, saved); end
        drive_a(CT128, cyc);
        checks++; if (cyc != 11 || a_dout !== PT) begin fails++; $display("FAIL abort_recover cyc %0d dout %h want 11 %h", cyc, a_dout, PT); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int cyc;
        a_din = CT128;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL rst_run ov %b busy %b ir %b want 0 0 1", a_out_valid, a_busy, a_in_ready); end
        checks++; if (a_dout !== 128'h0 || a_key_idx !== 4'd10 || a_rnd_last !== 1'b0) begin fails++; $display("FAIL rst_run_state dout %h kidx %0d last %b want 0 10 0", a_dout, a_key_idx, a_rnd_last); end
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b0;
        drive_a(CT128, cyc);
        #2 rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin fails++; $display("FAIL rst_done ov %b busy %b want 0 0", a_out_valid, a_busy); end
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        drive_a(CT128, cyc);
        checks++; if (cyc != 11 || a_dout !== PT) begin fails++; $display("FAIL rst_recover cyc %0d dout %h want 11 %h", cyc, a_dout, PT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        int acc_t[$];
        int out_t[$];
        int nb;
        int no;
        expand_key({rnd128(), 128'h0}, 4, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pts[i] = rnd128();
            cts[i] = encrypt(pts[i]);
        end
        a_out_ready = 1'b1;
        nb = 0;
        no = 0;
        for (int t = 0; t < 60; t++) begin
            if (a_out_valid) begin
                checks++; if (no >= 3 || a_dout !== pts[no]) begin fails++; $display("FAIL b2b_dout[%0d] got %h want %h", no, a_dout, (no < 3) ? pts[no] : 128'h0); end
                out_t.push_back(t);
                no++;
            end
            a_in_valid = (nb < 3);
            if (nb < 3) a_din = cts[nb];
            if (a_in_ready && nb < 3) begin
                acc_t.push_back(t);
                nb++;
            end
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        checks++; if (acc_t.size() != 3 || out_t.size() != 3) begin fails++; $display("FAIL b2b_counts acc %0d out %0d want 3 3", acc_t.size(), out_t.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (out_t[i] - acc_t[i] != 11) begin fails++; $display("FAIL b2b_latency[%0d] got %0d want 11", i, out_t[i] - acc_t[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                checks++; if (acc_t[i+1] - acc_t[i] != 12) begin fails++; $display("FAIL b2b_interval[%0d] got %0d want 12", i, acc_t[i+1] - acc_t[i]); end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] pt;
        logic [127:0] ct;
        int hold;
        int n;
        int cyc;
        for (int b = 0; b < 10; b++) begin
            expand_key({rnd128(), 128'h0}, 4, 10, 1'b0);
            pt = rnd128();
            ct = encrypt(pt);
            hold = $urandom_range(0, 3);
            a_out_ready = 1'b0;
            n = 0;
            while (!a_in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            a_din = ct;
            a_in_valid = 1'b1;
            @(negedge clk);
            cyc = 1;
            while (!a_out_valid && cyc < 40) begin
                a_in_valid = 1'($urandom_range(0, 1));
                a_din = rnd128();
                @(negedge clk);
                cyc++;
            end
            a_in_valid = 1'b0;
            checks++; if (cyc != 11 || n >= 20) begin fails++; $display("FAIL rand[%0d]_latency got %0d want 11", b, cyc); end
            checks++; if (a_dout !== pt) begin fails++; $display("FAIL rand[%0d]_dout got %h want %h", b, a_dout, pt); end
            repeat (hold) begin
                @(negedge clk);
                checks++; if (a_out_valid !== 1'b1 || a_dout !== pt) begin fails++; $display("FAIL rand[%0d]_hold ov %b dout %h want 1 %h", b, a_out_valid, a_dout, pt); end
            end
            a_out_ready = 1'b1;
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL rand[%0d]_release ov %b ir %b want 0 1", b, a_out_valid, a_in_ready); end
        end
    endtask

    task automatic test_aes256();
        int cyc;
        expand_key(K256, 8, 14, 1'b1);
        b_out_ready = 1'b1;
        checks++; if (b_key_idx !== 4'd14 || b_in_ready !== 1'b1) begin fails++; $display("FAIL aes256_idle kidx %0d ir %b want 14 1", b_key_idx, b_in_ready); end
        b_din = CT256;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        cyc = 1;
        while (!b_out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc != 15) begin fails++; $display("FAIL aes256_latency got %0d want 15", cyc); end
        checks++; if (b_dout !== PT) begin fails++; $display("FAIL aes256_dout got %h want %h", b_dout, PT); end
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin fails++; $display("FAIL aes256_release ov %b ir %b want 0 1", b_out_valid, b_in_ready); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips128();
        test_backpressure();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        test_aes256();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
